// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: redirect kinds, special instruction words,
// and fetch state encoding.
package mips_pkg;

  localparam logic [1:0] RK_BRANCH = 2'b00;
  localparam logic [1:0] RK_JUMP   = 2'b01;
  localparam logic [1:0] RK_JR     = 2'b10;
  localparam logic [1:0] RK_RSVD   = 2'b11;

  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEF = 32'h1000_FFFF;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect target computation for BRANCH / JUMP / JR.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [31:0] pc4,
  input  logic [25:0] imm,
  input  logic [31:0] reg_val,
  output logic [31:0] target,
  output logic        misaligned
);

  // Select target by redirect kind; reserved kind yields pc4 and is ignored upstream.
  always_comb begin
    target     = pc4;
    misaligned = 1'b0;
    case (kind)
      RK_BRANCH: target = pc4 + {{14{imm[15]}}, imm[15:0], 2'b00};
      RK_JUMP:   target = {pc4[31:28], imm, 2'b00};
      RK_JR: begin
        target     = {reg_val[31:2], 2'b00};
        misaligned = |reg_val[1:0];
      end
      default:   target = pc4;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and fills
// the IF/ID register with stall / flush / redirect handling and HALT detection.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned IMEM_AW   = 8,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_kind,
  input  logic [31:0] redirect_pc4,
  input  logic [25:0] redirect_imm,
  input  logic [31:0] redirect_reg,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic        jr_misaligned,
  output logic        pc_out_of_range
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic         halted_q, halted_d;
  logic         jr_mis_q, jr_mis_d;

  logic [31:0]  target;
  logic         misaligned;
  logic         redir;
  logic [31:0]  pc_plus4;

  next_pc_calc u_next_pc_calc (
    .kind       (redirect_kind),
    .pc4        (redirect_pc4),
    .imm        (redirect_imm),
    .reg_val    (redirect_reg),
    .target     (target),
    .misaligned (misaligned)
  );

  assign redir           = redirect_valid && (redirect_kind != RK_RSVD);
  assign pc_plus4        = pc_q + 32'd4;
  assign imem_addr       = pc_q;
  assign pc_out_of_range = |pc_q[31:IMEM_AW+2];
  assign ifid_instr      = instr_q;
  assign ifid_pc4        = pc4_q;
  assign ifid_valid      = valid_q;
  assign halted          = halted_q;
  assign jr_misaligned   = jr_mis_q;

  // Next-state / next-PC / IF/ID selection, priority redirect > stall > flush > normal.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    jr_mis_d = redir && misaligned;
    case (state_q)
      ST_START: begin
        if (redir) pc_d = target;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redir) begin
          pc_d    = target;
          instr_d = NOP_WORD;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else if (stall) begin
          if (flush) begin
            instr_d = NOP_WORD;
            pc4_d   = '0;
            valid_d = 1'b0;
          end
        end else if (flush) begin
          instr_d = NOP_WORD;
          pc4_d   = '0;
          valid_d = 1'b0;
          pc_d    = pc_plus4;
        end else begin
          instr_d = imem_instr;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          // The halt word is still delivered downstream; only the PC freezes.
          if (imem_instr == HALT_WORD) state_d = ST_HALT;
          else                         pc_d    = pc_plus4;
        end
      end
      ST_HALT: begin
        // A redirect back onto the halt PC is the halt branch itself resolving.
        if (redir && (target != pc_q)) begin
          state_d = ST_RUN;
          pc_d    = target;
          instr_d = NOP_WORD;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else if (!stall || flush) begin
          instr_d = NOP_WORD;
          pc4_d   = '0;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_START;
    endcase
    halted_d = (state_d == ST_HALT);
  end

  // Fetch state and IF/ID register, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_START;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_WORD;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      jr_mis_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      jr_mis_q <= jr_mis_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [1:0]  redirect_kind;
  logic [31:0] redirect_pc4;
  logic [25:0] redirect_imm;
  logic [31:0] redirect_reg;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic        jr_misaligned;
  logic        pc_out_of_range;

  logic [31:0] mem [256];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [31:0] HALTW = 32'h1000_FFFF;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[9:2]];

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_AW   (8),
    .HALT_WORD (32'h1000_FFFF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_kind   (redirect_kind),
    .redirect_pc4    (redirect_pc4),
    .redirect_imm    (redirect_imm),
    .redirect_reg    (redirect_reg),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .ifid_instr      (ifid_instr),
    .ifid_pc4        (ifid_pc4),
    .ifid_valid      (ifid_valid),
    .halted          (halted),
    .jr_misaligned   (jr_misaligned),
    .pc_out_of_range (pc_out_of_range)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [1:0] k, input logic [31:0] p4,
                          input logic [25:0] imm, input logic [31:0] rv);
    redirect_valid = 1'b1;
    redirect_kind  = k;
    redirect_pc4   = p4;
    redirect_imm   = imm;
    redirect_reg   = rv;
  endtask

  function automatic logic [31:0] w(input int unsigned i);
    return 32'h2000_0000 | i;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = w(i);
    mem[13] = HALTW;

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_kind = 2'b00;
    redirect_pc4 = '0; redirect_imm = '0; redirect_reg = '0;
    #2;
    check("rst_addr",   imem_addr, 32'h0);
    check("rst_instr",  ifid_instr, 32'h0);
    check("rst_pc4",    ifid_pc4, 32'h0);
    check("rst_valid",  {31'b0, ifid_valid}, 32'd1 - 32'd1);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_jrmis",  {31'b0, jr_misaligned}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Startup: START holds pc at 0, then sequential fetch
    step();
    check("start_addr",  imem_addr, 32'h0);
    check("start_valid", {31'b0, ifid_valid}, 32'h0);
    step();
    check("f0_instr", ifid_instr, w(0));
    check("f0_pc4",   ifid_pc4, 32'h4);
    check("f0_valid", {31'b0, ifid_valid}, 32'h1);
    check("f0_addr",  imem_addr, 32'h4);
    step();
    check("f1_instr", ifid_instr, w(1));
    check("f1_addr",  imem_addr, 32'h8);

    // Stall held 3 cycles at pc 0x8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr",  imem_addr, 32'h8);
      check("stall_instr", ifid_instr, w(1));
      check("stall_valid", {31'b0, ifid_valid}, 32'h1);
    end
    flush = 1'b1;
    step();
    check("stflush_valid", {31'b0, ifid_valid}, 32'h0);
    check("stflush_addr",  imem_addr, 32'h8);
    stall = 1'b0;
    step();
    check("flush_valid", {31'b0, ifid_valid}, 32'h0);
    check("flush_addr",  imem_addr, 32'hC);
    flush = 1'b0;
    step();
    check("f3_instr", ifid_instr, w(3));
    check("f3_pc4",   ifid_pc4, 32'h10);
    check("f3_addr",  imem_addr, 32'h10);

    // BRANCH redirect with simultaneous stall: 0x34 + (-8 << 2) = 0x14
    redirect(2'b00, 32'h34, 26'h000_FFF8, 32'h0);
    stall = 1'b1;
    step();
    check("br_addr",  imem_addr, 32'h14);
    check("br_valid", {31'b0, ifid_valid}, 32'h0);
    check("br_instr", ifid_instr, 32'h0);
    redirect_valid = 1'b0; stall = 1'b0;
    step();
    check("br_f5_instr", ifid_instr, w(5));
    check("br_f5_pc4",   ifid_pc4, 32'h18);
    check("br_next",     imem_addr, 32'h18);

    // JUMP: {0x1, 26'h5, 00} = 0x1000_0014, out of range but aliases to word 5
    redirect(2'b01, 32'h1000_0010, 26'h5, 32'h0);
    step();
    check("j_addr",  imem_addr, 32'h1000_0014);
    check("j_oor",   {31'b0, pc_out_of_range}, 32'h1);
    check("j_valid", {31'b0, ifid_valid}, 32'h0);
    redirect_valid = 1'b0;
    step();
    check("alias_instr", ifid_instr, w(5));
    check("alias_pc4",   ifid_pc4, 32'h1000_0018);

    // JR with misaligned rs 0x23 -> 0x20, one-cycle pulse
    redirect(2'b10, 32'h0, 26'h0, 32'h0000_0023);
    step();
    check("jr_addr",  imem_addr, 32'h20);
    check("jr_mis1",  {31'b0, jr_misaligned}, 32'h1);
    check("jr_oor",   {31'b0, pc_out_of_range}, 32'h0);
    redirect_valid = 1'b0;
    step();
    check("jr_mis0",   {31'b0, jr_misaligned}, 32'h0);
    check("jr_f8",     ifid_instr, w(8));
    check("jr_f8addr", imem_addr, 32'h24);

    // Reserved kind acts as no redirect
    redirect(2'b11, 32'h0, 26'h0, 32'h0);
    step();
    check("rsv_instr", ifid_instr, w(9));
    check("rsv_addr",  imem_addr, 32'h28);
    redirect_valid = 1'b0;

    // Run into the halt word at 0x34
    step(); step(); step();
    check("pre_halt_addr", imem_addr, 32'h34);
    check("pre_halt_f12",  ifid_instr, w(12));
    step();
    check("halt_instr",  ifid_instr, HALTW);
    check("halt_valid",  {31'b0, ifid_valid}, 32'h1);
    check("halt_pc4",    ifid_pc4, 32'h38);
    check("halt_addr",   imem_addr, 32'h34);
    check("halt_flag",   {31'b0, halted}, 32'h1);
    step();
    check("halt_bubble", {31'b0, ifid_valid}, 32'h0);
    check("halt_hold",   imem_addr, 32'h34);
    check("halt_flag2",  {31'b0, halted}, 32'h1);

    // Halt branch resolving to itself: 0x38 + (-1 << 2) = 0x34
    redirect(2'b00, 32'h38, 26'h000_FFFF, 32'h0);
    step();
    check("self_halted", {31'b0, halted}, 32'h1);
    check("self_addr",   imem_addr, 32'h34);
    // Speculative halt: jump to 0x10
    redirect(2'b01, 32'h38, 26'h4, 32'h0);
    step();
    check("resume_halted", {31'b0, halted}, 32'h0);
    check("resume_addr",   imem_addr, 32'h10);
    check("resume_valid",  {31'b0, ifid_valid}, 32'h0);
    redirect_valid = 1'b0;
    step();
    check("resume_f4",   ifid_instr, w(4));
    check("resume_next", imem_addr, 32'h14);

    // Re-enter HALT, then async reset mid-cycle
    redirect(2'b01, 32'h0, 26'hD, 32'h0);
    step();
    check("rejump_addr", imem_addr, 32'h34);
    redirect_valid = 1'b0;
    step();
    check("rehalt_flag", {31'b0, halted}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("areset_halted", {31'b0, halted}, 32'h0);
    check("areset_addr",   imem_addr, 32'h0);
    check("areset_valid",  {31'b0, ifid_valid}, 32'h0);
    check("areset_instr",  ifid_instr, 32'h0);
    #1;
    reset = 1'b0;
    step();
    check("restart_addr",  imem_addr, 32'h0);
    check("restart_valid", {31'b0, ifid_valid}, 32'h0);
    step();
    check("restart_f0",   ifid_instr, w(0));
    check("restart_addr4", imem_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
